// File: rtl/fifo_pkg.sv
// Shared constants and state encoding for the FIFO write-side arbiter.
package fifo_pkg;

  localparam int FIFO_WIDTH_DEF = 16;
  localparam int NUM_REQ_DEF    = 4;
  localparam int BURST_LEN_DEF  = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester at or above rr_ptr_i, wrapping.
module rr_pick #(
  parameter int NUM_REQ = 4,
  localparam int IW = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IW-1:0]      rr_ptr_i,
  output logic [IW-1:0]      idx_o,
  output logic               valid_o
);

  logic [IW:0] sum;

  // Scan offsets from the far end down so the nearest offset to rr_ptr_i wins.
  always_comb begin
    idx_o   = '0;
    valid_o = 1'b0;
    sum     = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      sum = {1'b0, rr_ptr_i} + (IW+1)'(k);
      if (sum >= (IW+1)'(NUM_REQ)) begin
        sum = sum - (IW+1)'(NUM_REQ);
      end
      if (req_i[sum[IW-1:0]]) begin
        idx_o   = sum[IW-1:0];
        valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter feeding one FIFO write port from NUM_REQ word sources.
// state | meaning
// IDLE  | arbitration cycle; pick next owner from rr_ptr upward
// GRANT | owner streams up to BURST_LEN words, stalls on fifo_full
module fifo_wr_arbiter
  import fifo_pkg::*;
#(
  parameter int FIFO_WIDTH = FIFO_WIDTH_DEF,
  parameter int NUM_REQ    = NUM_REQ_DEF,
  parameter int BURST_LEN  = BURST_LEN_DEF,
  localparam int OW = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*FIFO_WIDTH-1:0] din,
  output logic [NUM_REQ-1:0]            ack,
  input  logic                          fifo_full,
  output logic                          fifo_wen,
  output logic [FIFO_WIDTH-1:0]         fifo_din,
  output logic                          busy,
  output logic [OW-1:0]                 owner
);

  localparam logic [7:0]    BURST_CNT = 8'(BURST_LEN);
  localparam logic [OW-1:0] LAST_IDX  = OW'(NUM_REQ - 1);

  arb_state_e      state_q, state_d;
  logic [OW-1:0]   owner_q, owner_d;
  logic [OW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [7:0]      beat_cnt_q, beat_cnt_d;

  logic [OW-1:0]   pick_idx;
  logic            pick_valid;
  logic            req_own;
  logic [OW-1:0]   next_ptr;
  logic [FIFO_WIDTH-1:0] din_arr [NUM_REQ];

  rr_pick #(.NUM_REQ(NUM_REQ)) u_rr_pick (
    .req_i    (req),
    .rr_ptr_i (rr_ptr_q),
    .idx_o    (pick_idx),
    .valid_o  (pick_valid)
  );

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      din_arr[i] = din[i*FIFO_WIDTH +: FIFO_WIDTH];
    end
  end

  assign req_own  = req[owner_q];
  assign next_ptr = (owner_q == LAST_IDX) ? '0 : owner_q + OW'(1);
  assign owner    = owner_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      owner_q    <= '0;
      rr_ptr_q   <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      rr_ptr_q   <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    rr_ptr_d   = rr_ptr_q;
    beat_cnt_d = beat_cnt_q;
    fifo_wen   = 1'b0;
    fifo_din   = '0;
    ack        = '0;
    busy       = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          owner_d    = pick_idx;
          beat_cnt_d = '0;
          state_d    = GRANT;
        end
      end
      GRANT: begin
        busy          = 1'b1;
        fifo_din      = din_arr[owner_q];
        fifo_wen      = req_own && !fifo_full;
        ack[owner_q]  = fifo_wen;
        if (fifo_wen) begin
          beat_cnt_d = beat_cnt_q + 8'd1;
        end
        // Release on the final beat or as soon as the owner runs dry, even while full.
        if (!req_own || (fifo_wen && (beat_cnt_q + 8'd1 == BURST_CNT))) begin
          state_d  = IDLE;
          rr_ptr_d = next_ptr;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter: sources push expected words, a negedge monitor checks writes.
module tb_fifo_wr_arbiter;

  localparam int W = 16;
  localparam int N = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [N-1:0]     req;
  logic [N*W-1:0]   din;
  logic [N-1:0]     ack;
  logic             fifo_full;
  logic             fifo_wen;
  logic [W-1:0]     fifo_din;
  logic             busy;
  logic [1:0]       owner;

  fifo_wr_arbiter #(.FIFO_WIDTH(W), .NUM_REQ(N), .BURST_LEN(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .din       (din),
    .ack       (ack),
    .fifo_full (fifo_full),
    .fifo_wen  (fifo_wen),
    .fifo_din  (fifo_din),
    .busy      (busy),
    .owner     (owner)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         idx;
    logic [W-1:0] data;
  } exp_t;

  exp_t         exp_q[$];
  int           ord_q[$];
  int           left[N];
  logic [W-1:0] nxt[N];
  logic [W-1:0] rnd_nxt[N];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int wen_total = 0;
  int last_wen = 0;
  logic [N-1:0] ack_s = '0;

  for (genvar g = 0; g < N; g++) begin : g_src
    assign req[g]       = (left[g] != 0);
    assign din[g*W +: W] = nxt[g];
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req_v);
    checks++;
    if (act !== req_v) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req_v, $time);
    end
  endtask

  // Monitor: invariants every cycle, scoreboard pop on every write.
  always @(negedge clk) begin
    logic [N-1:0] ea;
    int pos;
    cyc++;
    ack_s = ack;
    ea = '0;
    if (fifo_wen) ea[owner] = 1'b1;
    chk("ack_vs_wen", ack, ea);
    chk("wen_while_full", fifo_wen & fifo_full, 0);
    if (!busy) chk("din_idle_zero", fifo_din, 0);
    if (fifo_wen) begin
      wen_total++;
      last_wen = cyc;
      pos = -1;
      for (int k = 0; k < exp_q.size(); k++) begin
        if (pos < 0 && exp_q[k].idx == int'(owner)) pos = k;
      end
      chk("pending_for_owner", (pos >= 0), 1);
      if (pos >= 0) begin
        chk($sformatf("data_r%0d", owner), fifo_din, exp_q[pos].data);
        exp_q.delete(pos);
      end
      if (ord_q.size() > 0) chk("grant_order", owner, ord_q.pop_front());
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (ack_s[i] && left[i] > 0) begin
        left[i]--;
        nxt[i]++;
      end
    end
  endtask

  task automatic load(input int i, input int n, input logic [W-1:0] first);
    exp_t e;
    left[i] = n;
    nxt[i]  = first;
    for (int k = 0; k < n; k++) begin
      e.idx  = i;
      e.data = first + W'(k);
      exp_q.push_back(e);
    end
  endtask

  task automatic push_ord(input int i, input int n);
    for (int k = 0; k < n; k++) ord_q.push_back(i);
  endtask

  task automatic drain(input string name, input int bound);
    int t = 0;
    while ((exp_q.size() != 0 || busy) && t < bound) begin
      tick();
      t++;
    end
    chk({name, "_pending"}, exp_q.size(), 0);
    chk({name, "_order_left"}, ord_q.size(), 0);
    tick();
    tick();
  endtask

  task automatic wait_beats(input int w0, input int n, input int bound);
    int t = 0;
    while ((wen_total - w0) < n && t < bound) begin
      tick();
      t++;
    end
    chk("beats_reached", wen_total - w0, n);
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_wen"}, fifo_wen, 0);
    chk({tag, "_ack"}, ack, 0);
    chk({tag, "_din"}, fifo_din, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_owner"}, owner, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int l0, w0;
    rst_n = 1'b0;
    fifo_full = 1'b0;
    for (int i = 0; i < N; i++) begin
      left[i] = 0;
      nxt[i] = '0;
      rnd_nxt[i] = W'((i << 12) | 'h800);
    end
    #1;
    chk_outputs_zero("reset");
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // All four requesting from reset: 0,1,2,3,0 bursts of four.
    l0 = cyc; w0 = wen_total;
    load(0, 8, 16'h0001);
    load(1, 4, 16'h0101);
    load(2, 4, 16'h0201);
    load(3, 4, 16'h0301);
    push_ord(0, 4); push_ord(1, 4); push_ord(2, 4); push_ord(3, 4); push_ord(0, 4);
    drain("all4", 200);
    chk("all4_wen_count", wen_total - w0, 20);
    chk("all4_span", last_wen - l0, 25);

    // Single requester: two bursts separated by exactly one idle cycle.
    l0 = cyc; w0 = wen_total;
    load(0, 8, 16'h0001);
    push_ord(0, 8);
    drain("single", 100);
    chk("single_wen_count", wen_total - w0, 8);
    chk("single_span", last_wen - l0, 10);

    // Owner 1 runs dry after two beats; rr_ptr=2 skips idle 2, lands on 3.
    l0 = cyc; w0 = wen_total;
    load(1, 2, 16'h0111);
    load(3, 4, 16'h0311);
    push_ord(1, 2); push_ord(3, 4);
    drain("early_rel", 100);
    chk("early_rel_span", last_wen - l0, 9);

    // Owner 2 stalled by fifo_full for five cycles after beat 2.
    l0 = cyc; w0 = wen_total;
    load(2, 4, 16'h0221);
    push_ord(2, 4);
    wait_beats(w0, 2, 50);
    fifo_full = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("stall_wen", fifo_wen, 0);
      chk("stall_ack", ack, 0);
      chk("stall_busy", busy, 1);
      tick();
    end
    chk("stall_beat_cnt", dut.beat_cnt_q, 2);
    fifo_full = 1'b0;
    drain("stall", 100);
    chk("stall_span", last_wen - l0, 10);
    chk("stall_beat_end", dut.beat_cnt_q, 4);

    // Async reset mid-burst with owner 3, then requester 0 first.
    w0 = wen_total;
    load(3, 4, 16'h0341);
    push_ord(3, 2);
    wait_beats(w0, 2, 50);
    rst_n = 1'b0;
    #1;
    chk_outputs_zero("midrst");
    for (int k = exp_q.size() - 1; k >= 0; k--) begin
      if (exp_q[k].idx == 3) exp_q.delete(k);
    end
    left[3] = 0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    l0 = cyc;
    load(0, 1, 16'h0051);
    load(3, 1, 16'h0351);
    push_ord(0, 1); push_ord(3, 1);
    drain("post_rst", 100);
    chk("post_rst_span", last_wen - l0, 5);

    // Random sources and back-pressure; per-requester order via scoreboard.
    for (int c = 0; c < 500; c++) begin
      fifo_full = ($urandom_range(0, 3) == 0);
      for (int i = 0; i < N; i++) begin
        if (left[i] == 0 && $urandom_range(0, 2) == 0) begin
          int n;
          n = $urandom_range(1, 6);
          load(i, n, rnd_nxt[i]);
          rnd_nxt[i] = rnd_nxt[i] + W'(n);
        end
      end
      tick();
    end
    fifo_full = 1'b0;
    drain("random", 1000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
